// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu_arbiter slice: ALU opcodes, FSM encoding, default width.
// The optional performance counters in alu_arbiter are enabled with ALU_ARB_PERF_CNT_EN.
package alu_arbiter_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_AND = 4'b0010;
    localparam logic [3:0] ALU_OP_OR  = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first asserted req strictly after ptr, wrapping modulo N.
// Used by alu_arbiter; ptr holds the index of the previous winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu32 between NUM_REQ requesters, one operation in flight at a time.
// Define ALU_ARB_PERF_CNT_EN to add the grant_cnt/ovf_cnt saturating counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    parameter int DATA_W  = ALU_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_sel,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_out,
    output logic                      rsp_ovf,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [3:0]                alu_sel,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_overflow,
    output logic                      busy
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
    output logic [15:0]               ovf_cnt
`endif
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high.
    // req_ready is a combinational one-hot grant in IDLE; rsp_valid holds until its rsp_ready.

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = ($clog2(ALU_LAT + 1) < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               accept;
    logic               capture;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                req_ready = arb_grant;
                accept    = arb_any;
                if (arb_any) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                capture = (cnt == CNT_ONE);
                if (cnt == CNT_ONE) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid[gidx] = 1'b1;
                if (rsp_ready[gidx]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 4'b0000;
            rsp_out <= '0;
            rsp_ovf <= 1'b0;
            gidx    <= '0;
            ptr     <= IDX_W'(NUM_REQ - 1);
            cnt     <= '0;
        end else begin
            if (accept) begin
                alu_a   <= req_a[arb_idx*DATA_W +: DATA_W];
                alu_b   <= req_b[arb_idx*DATA_W +: DATA_W];
                alu_sel <= req_sel[arb_idx*4 +: 4];
                gidx    <= arb_idx;
                ptr     <= arb_idx;
                cnt     <= CNT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_ONE;
            end
            if (capture) begin
                rsp_out <= alu_out;
                rsp_ovf <= alu_overflow;
            end
        end
    end

`ifdef ALU_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            ovf_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && arb_idx == IDX_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
            if (capture && alu_overflow && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
// A second instance with ALU_LAT=3 and an XOR stub ALU checks the longer latency.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LAT = 1;
    localparam int SLAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0] req_a, req_b;
    logic [NR*4-1:0]  req_sel;
    logic [DW-1:0]    rsp_out, alu_a, alu_b, alu_out;
    logic [3:0]       alu_sel;
    logic             rsp_ovf, alu_overflow, busy;

    logic [NR-1:0]    s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [NR*DW-1:0] s_req_a, s_req_b;
    logic [NR*4-1:0]  s_req_sel;
    logic [DW-1:0]    s_rsp_out, s_alu_a, s_alu_b, s_alu_out, s_p1, s_p2;
    logic [3:0]       s_alu_sel;
    logic             s_rsp_ovf, s_alu_overflow, s_busy;

`ifdef ALU_ARB_PERF_CNT_EN
    logic [NR*16-1:0] grant_cnt, s_grant_cnt;
    logic [15:0]      ovf_cnt, s_ovf_cnt;
`endif

    alu_arbiter #(.NUM_REQ(NR), .ALU_LAT(LAT), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_ovf(rsp_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
`ifdef ALU_ARB_PERF_CNT_EN
        .grant_cnt(grant_cnt), .ovf_cnt(ovf_cnt),
`endif
        .busy(busy)
    );

    alu_arbiter #(.NUM_REQ(NR), .ALU_LAT(SLAT), .DATA_W(DW)) dut_slow (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .req_sel(s_req_sel),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_out(s_rsp_out), .rsp_ovf(s_rsp_ovf),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel),
        .alu_out(s_alu_out), .alu_overflow(s_alu_overflow),
`ifdef ALU_ARB_PERF_CNT_EN
        .grant_cnt(s_grant_cnt), .ovf_cnt(s_ovf_cnt),
`endif
        .busy(s_busy)
    );

    // Reference alu32 behaviour: combinational, so LAT=1 samples it on the next edge.
    function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [3:0] sel);
        logic [DW-1:0] r;
        logic o;
        r = '0;
        o = 1'b0;
        case (sel)
            ALU_OP_ADD: begin r = a + b; o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            ALU_OP_SUB: begin r = a - b; o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            ALU_OP_AND: r = a & b;
            ALU_OP_OR:  r = a | b;
            ALU_OP_XOR: r = a ^ b;
            ALU_OP_SLL: r = a << b[4:0];
            ALU_OP_SRL: r = a >> b[4:0];
            ALU_OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:    r = ~a;
        endcase
        return {o, r};
    endfunction

    assign {alu_overflow, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    // Two-register XOR stub: result is settled before the third WAIT edge samples it.
    always @(posedge clk) begin
        s_p1 <= s_alu_a ^ s_alu_b;
        s_p2 <= s_p1;
    end
    assign s_alu_out      = s_p2;
    assign s_alu_overflow = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: an op is free/in-flight, its response is due ALU_LAT+1
    // cycles after the accept cycle, and results are queued in accept order.
    int            cyc;
    bit            m_inflight;
    int            m_owner, m_last, m_resp_cyc;
    logic [DW-1:0] m_a, m_b;
    logic [3:0]    m_sel;
    logic [DW:0]   exp_q[$];
    int            g_cnt[NR];
    int            m_ovf_cnt;

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy, exp_rv;
        logic [DW:0]   head;
        int            g;
        bit            found;
        if (!rst_n) begin
            m_inflight = 0;
            m_last     = NR - 1;
            cyc        = 0;
            m_ovf_cnt  = 0;
            exp_q.delete();
            for (int i = 0; i < NR; i++) g_cnt[i] = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_sel", alu_sel, 0);
            chk("rst_rsp_out", rsp_out, 0);
            chk("rst_rsp_ovf", rsp_ovf, 0);
        end else begin
            exp_rdy = '0;
            exp_rv  = '0;
            found   = 0;
            g       = 0;
            head    = '0;
            if (exp_q.size() > 0) head = exp_q[0];
            if (!m_inflight) begin
                for (int k = 1; k <= NR; k++) begin
                    if (!found && req_valid[(m_last + k) % NR]) begin
                        found = 1;
                        g = (m_last + k) % NR;
                    end
                end
                if (found) exp_rdy[g] = 1'b1;
            end else if (cyc >= m_resp_cyc) begin
                exp_rv[m_owner] = 1'b1;
                if (cyc == m_resp_cyc && head[DW]) m_ovf_cnt++;
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("busy", busy, m_inflight);
            if (m_inflight) begin
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
                chk("alu_sel", alu_sel, m_sel);
            end
            if (exp_rv != 0) begin
                chk("rsp_out", rsp_out, head[DW-1:0]);
                chk("rsp_ovf", rsp_ovf, head[DW]);
            end
`ifdef ALU_ARB_PERF_CNT_EN
            for (int i = 0; i < NR; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], g_cnt[i]);
            chk("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
            if (found) begin
                m_inflight = 1;
                m_owner    = g;
                m_last     = g;
                m_resp_cyc = cyc + LAT + 1;
                m_a        = req_a[g*DW +: DW];
                m_b        = req_b[g*DW +: DW];
                m_sel      = req_sel[g*4 +: 4];
                exp_q.push_back(alu_f(m_a, m_b, m_sel));
                g_cnt[g]++;
            end else if (exp_rv != 0 && rsp_ready[m_owner]) begin
                m_inflight = 0;
                void'(exp_q.pop_front());
            end
            cyc++;
        end
    end

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom);
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return DW'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic rand_ops(input int i);
        req_a[i*DW +: DW] = pick_operand();
        req_b[i*DW +: DW] = pick_operand();
        req_sel[i*4 +: 4] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int i);
        int n;
        req_valid[i] = 1'b1;
        rand_ops(i);
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_grant", req_ready[i], 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int            n;
        int            gl[$];
        int            gc[$];
        logic [DW-1:0] held;
        logic [DW:0]   ref_v;
        logic [NR-1:0] rdy;

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '0;
        s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_req_sel = '0; s_rsp_ready = '1;
        #3;
        chk("por_busy", busy, 0);
        chk("por_alu_a", alu_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADD from requester 0: 1+1 = 2, no overflow, response two cycles after accept.
        @(posedge clk); #1;
        req_a[0 +: DW] = 32'd1; req_b[0 +: DW] = 32'd1; req_sel[0 +: 4] = ALU_OP_ADD;
        req_valid = 4'b0001; rsp_ready = '1;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_rv_wait", rsp_valid, 4'b0000);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_rv", rsp_valid, 4'b0001);
        chk("t1_out", rsp_out, 32'h2);
        chk("t1_ovf", rsp_ovf, 0);
        @(posedge clk); #1;

        // All requesters valid, responses always accepted: rotating grants every 3 cycles.
        for (int i = 0; i < NR; i++) rand_ops(i);
        req_valid = '1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    gl.push_back(i);
                    gc.push_back(k);
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        chk("t2_count", gl.size(), 8);
        for (int k = 0; k < gl.size(); k++) begin
            chk("t2_order", gl[k], (1 + k) % NR);
            if (k > 0) chk("t2_interval", gc[k] - gc[k-1], 3);
        end
        wait_idle();

        // Response back-pressure on requester 2 for five cycles.
        rsp_ready = 4'b1011;
        rand_ops(2);
        req_valid = 4'b0100;
        n = 0;
        @(negedge clk);
        while (!req_ready[2] && n < 20) begin @(negedge clk); n++; end
        chk("t3_grant", req_ready, 4'b0100);
        ref_v = alu_f(req_a[2*DW +: DW], req_b[2*DW +: DW], req_sel[8 +: 4]);
        @(posedge clk); #1;
        rand_ops(0);
        req_valid = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[2] && n < 20) begin @(negedge clk); n++; end
        held = rsp_out;
        chk("t3_out", held, ref_v[DW-1:0]);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_hold_rv", rsp_valid, 4'b0100);
            chk("t3_hold_out", rsp_out, held);
            chk("t3_hold_rdy", req_ready, 4'b0000);
        end
        @(posedge clk); #1 rsp_ready = '1;
        @(negedge clk);
        chk("t3_release_rv", rsp_valid, 4'b0100);
        @(negedge clk);
        chk("t3_next_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // Asynchronous reset while an op from requester 3 is waiting on the ALU.
        rand_ops(3);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t4_grant", req_ready, 4'b1000);
        @(posedge clk); #1 req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_alu_a", alu_a, 0);
        chk("t4_alu_sel", alu_sel, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_rsp_out", rsp_out, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) rand_ops(i);
        req_valid = '1;
        @(negedge clk);
        chk("t4_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // Random traffic: legal drops before grant, random response back-pressure.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    rand_ops(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    rand_ops(i);
                end
            end
            rsp_ready = NR'($urandom_range(0, (1 << NR) - 1));
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle();

`ifdef ALU_ARB_PERF_CNT_EN
        rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1); do_op(1); do_op(3); do_op(1);
        chk("perf_cnt0", grant_cnt[0 +: 16], 0);
        chk("perf_cnt1", grant_cnt[16 +: 16], 3);
        chk("perf_cnt2", grant_cnt[32 +: 16], 0);
        chk("perf_cnt3", grant_cnt[48 +: 16], 1);
`else
        do_op(1); do_op(3);
`endif

        // Slow instance: response four cycles after accept, rsp_out = a ^ b, overflow set.
        for (int t = 0; t < 3; t++) begin
            int            ri;
            logic [DW-1:0] ta, tb;
            ri = $urandom_range(0, NR - 1);
            ta = DW'($urandom);
            tb = DW'($urandom);
            s_req_a[ri*DW +: DW] = ta;
            s_req_b[ri*DW +: DW] = tb;
            s_req_sel[ri*4 +: 4] = 4'($urandom_range(0, 15));
            s_req_valid[ri] = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_req_ready[ri] && n < 20) begin @(negedge clk); n++; end
            chk("s_grant", s_req_ready, NR'(1) << ri);
            @(posedge clk); #1 s_req_valid = '0;
            n = 0;
            while (s_rsp_valid == 0 && n < 12) begin
                @(negedge clk);
                n++;
                if (n == 2) chk("s_alu_sel", s_alu_sel, s_req_sel[ri*4 +: 4]);
            end
            chk("s_latency", n, SLAT + 1);
            chk("s_rsp_valid", s_rsp_valid, NR'(1) << ri);
            chk("s_rsp_out", s_rsp_out, ta ^ tb);
            chk("s_rsp_ovf", s_rsp_ovf, 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("s_idle", s_busy, 0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
